// File: rtl/pattern_response_capture.sv
// Capture end of the exhaustive-stimulus flow: stores one response bit per pattern, tracks coverage and errors, and folds the record stream into a MISR.
// Latency: a record is reflected in coverage/signature/flags on the edge that accepts it; the read port returns data one cycle after rd_addr is presented.
// Backpressure: in_ready is a registered status that is high until every pattern has been captured, then low until reset or clear.
//
// Ports:
//   CK, reset (sync, active-low), clear (sync soft clear)
//   in_valid / in_ready / in_pattern / in_response : record handshake
//   rd_addr -> rd_data, rd_seen                    : registered table read
//   coverage, signature, done, dup_err, seq_err    : status
module pattern_response_capture #(
  parameter int              N_IN  = 5,
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h8005
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_pattern,
  input  logic             in_response,
  input  logic [N_IN-1:0]  rd_addr,
  output logic             rd_data,
  output logic             rd_seen,
  output logic [N_IN:0]    coverage,
  output logic [SIG_W-1:0] signature,
  output logic             done,
  output logic             dup_err,
  output logic             seq_err
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN:0] COV_LAST = (N_IN+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic [DEPTH-1:0]   seen_q;
  logic               mem [DEPTH];
  logic [N_IN:0]      cov_q;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic               dup_q, seq_q;
  logic [N_IN-1:0]    exp_q;
  logic               rd_data_q, rd_seen_q;

  logic wipe, take, is_new, complete;

  // reset and clear share one path; either one drops a same-cycle record
  assign wipe     = !reset || clear;
  assign take     = in_valid && ready_q && !wipe;
  assign is_new   = !seen_q[in_pattern];
  assign complete = take && is_new && (cov_q == COV_LAST);

  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ SIG_W'({in_pattern, in_response});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (take) state_d = complete ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (complete) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (wipe) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // derived from the next state so in_ready drops on the same edge DONE is entered
      ready_q <= (state_d != S_DONE);
    end
  end

  always_ff @(posedge CK) begin
    if (wipe) begin
      seen_q    <= '0;
      cov_q     <= '0;
      sig_q     <= '0;
      dup_q     <= 1'b0;
      seq_q     <= 1'b0;
      exp_q     <= '0;
      rd_data_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      if (take) begin
        if (is_new) begin
          seen_q[in_pattern] <= 1'b1;
          cov_q              <= cov_q + 1'b1;
        end else begin
          dup_q <= 1'b1;
        end
        if (in_pattern != exp_q) seq_q <= 1'b1;
        exp_q <= in_pattern + N_IN'(1);
        sig_q <= sig_d;
      end
      // read samples pre-edge contents, so a colliding write returns the old value
      rd_data_q <= mem[rd_addr];
      rd_seen_q <= seen_q[rd_addr];
    end
  end

  // table data is qualified by seen_q, so it is never cleared
  always_ff @(posedge CK) begin
    if (take && is_new) mem[in_pattern] <= in_response;
  end

  assign in_ready  = ready_q;
  assign rd_data   = rd_data_q;
  assign rd_seen   = rd_seen_q;
  assign coverage  = cov_q;
  assign signature = sig_q;
  assign done      = (state_q == S_DONE);
  assign dup_err   = dup_q;
  assign seq_err   = seq_q;

endmodule

// File: doc/pattern_response_capture.md
Name: pattern_response_capture

Overview:
- Hardware receive end of the exhaustive-stimulus flow: accepts one (pattern, response) record per handshake from the stimulus side and stores each response bit in a pattern-indexed table.
- Tracks pattern coverage, flags duplicate and out-of-order patterns, and compacts the record stream into a MISR signature.
- Sits behind the DUT in the trojan-detection capture path. Results are read back through a registered read port.

Parameters:
- N_IN, 5, pattern width; table depth is 2^N_IN entries.
- SIG_W, 16, MISR signature width; must be >= N_IN+1.
- POLY, 16'h8005, MISR feedback polynomial (SIG_W bits).

Ports:
- CK  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- clear  in  1  synchronous soft clear to post-reset state
- in_valid  in  1  record valid
- in_ready  out  1  block can accept a record
- in_pattern  in  N_IN  applied input pattern
- in_response  in  1  observed DUT output for that pattern
- rd_addr  in  N_IN  table read address
- rd_data  out  1  stored response at rd_addr (registered)
- rd_seen  out  1  entry at rd_addr has been written (registered)
- coverage  out  N_IN+1  count of distinct patterns captured
- signature  out  SIG_W  current MISR value
- done  out  1  all 2^N_IN patterns captured
- dup_err  out  1  sticky: a pattern arrived twice
- seq_err  out  1  sticky: a pattern arrived out of ascending order

Behaviour:
- Reset: one clock and reset are fixed. Reset is synchronous and active-low: when reset==0 at a rising CK edge, the block enters the post-reset state.
- Post-reset state: state=IDLE; in_ready=1; coverage=0; signature=0; done=0; dup_err=0; seq_err=0; rd_data=0; rd_seen=0; all seen bits=0; expected-pattern counter=0. Table data bits need not be cleared.
- clear==1 at an edge gives the same result as reset. clear takes priority over a same-cycle accept, so the record is dropped. reset takes priority over clear.
- Accept condition: in_valid && in_ready at the rising edge.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on the first accept.
  - CAPTURE -> DONE on the edge where the accept brings coverage to 2^N_IN.
  - DONE -> IDLE only via reset or clear.
- in_ready is 1 in IDLE and CAPTURE and 0 in DONE. It is a registered output with no combinational path from in_valid.
- On accept with seen[p]==0 (p = in_pattern):
  - mem[p] <= in_response
  - seen[p] <= 1
  - coverage += 1
- On accept with seen[p]==1:
  - mem[p] is NOT overwritten; coverage unchanged
  - dup_err <= 1 (sticky)
- Ordering check, on every accept:
  - if p != expected counter, seq_err <= 1 (sticky)
  - the expected counter then becomes p+1 mod 2^N_IN (wraps from all-ones to 0).
- MISR, on every accept including duplicates:
  - sig_n = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext({p, in_response})
  - signature <= sig_n
- done is 1 exactly when state==DONE, asserting the cycle after the completing accept.
- Read port:
  - 1-cycle latency: rd_data/rd_seen reflect mem[rd_addr]/seen[rd_addr] as sampled at the previous edge.
  - Reads are allowed in every state.
  - A same-cycle write and read to the same address returns the old value.
- Widths: coverage is N_IN+1 bits, so 2^N_IN is representable and never wraps, because coverage only increments on new patterns.
- Reset or clear mid-capture discards all progress. A subsequent pattern 0 is not a seq_err.

Test Plan:
- Reset then records p=0..31 in order, response = p[0] -> done=1 one cycle after the 32nd accept; coverage=32; in_ready=0; dup_err=0; seq_err=0; rd_addr=5 reads rd_data=1, rd_seen=1.
- After reset, p=0 resp=1 then p=1 resp=0 -> signature 0x0001 after the first accept, then 0x0000; coverage=2.
- p=3 resp=1, then p=3 resp=0 -> dup_err=1; coverage=1; rd_addr=3 gives rd_data=1 (first value kept); seq_err=1 (first record was not pattern 0).
- p=0,1,2, then clear asserted together with in_valid for p=3 -> coverage=0, signature=0, rd_seen[2]=0; p=3 is not stored; a following p=0 gives seq_err=0.
- Hold reset=0 for one edge during CAPTURE with coverage=17 -> all outputs return to reset values and in_ready=1. Reset=1 with in_valid held low -> no state change.
- In DONE, drive in_valid=1 with p=7 for 3 cycles -> no accept; signature, coverage and errors unchanged; done stays 1.
